// File: rtl/sta_pkg.sv
// ----------------------------------------------------------------------------
// sta_pkg
// Shared types for the systolic tensor array slice.
//   int8_t / int32_t : element and accumulator types (same as sys_types)
//   sta_state_e      : tile-level FSM states
//   ACC_W            : accumulator width
//   dot_w()          : exact width of a VEC_W-element int8 dot product
// No ports (package).
// ----------------------------------------------------------------------------
package sta_pkg;

  typedef logic signed [7:0]  int8_t;
  typedef logic signed [31:0] int32_t;

  localparam int ACC_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    FEED,
    FLUSH,
    DRAIN
  } sta_state_e;

  // Sum of vec_w signed 16-bit products never needs more than
  // 16 + clog2(vec_w) bits.
  function automatic int dot_w(input int vec_w);
    return 16 + $clog2(vec_w);
  endfunction

endpackage

// File: rtl/systolic_tensor_array_gen_if.sv
// ----------------------------------------------------------------------------
// systolic_tensor_array_gen_if
// Streaming bus of the tensor array: operand input handshake and per-row
// result drain handshake.
//   in_valid/in_ready : A/B beat handshake (master drives in_valid)
//   a_in              : ROWS x VEC_W signed int8 A vectors, unskewed
//   b_in              : COLS x VEC_W signed int8 B vectors, unskewed
//   out_valid/out_ready : drain beat handshake (slave drives out_valid)
//   out_row           : row index of the current drain beat
//   out_data          : COLS int32 accumulators of row out_row
// Modports: master = feeder/consumer side, slave = the array.
// ----------------------------------------------------------------------------
interface systolic_tensor_array_gen_if
  import sta_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int VEC_W = 4
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                              in_valid;
  logic                              in_ready;
  logic [ROWS-1:0][VEC_W-1:0][7:0]   a_in;
  logic [COLS-1:0][VEC_W-1:0][7:0]   b_in;
  logic                              out_valid;
  logic                              out_ready;
  logic [RW-1:0]                     out_row;
  logic [COLS-1:0][ACC_W-1:0]        out_data;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, out_row, out_data
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, out_row, out_data
  );

endinterface

// File: rtl/sta_skew_line.sv
// ----------------------------------------------------------------------------
// sta_skew_line
// DEPTH-stage delay line for one VEC_W x int8 operand lane. Shifts only when
// en is high, clears to zero on clr, DEPTH=0 is a plain wire.
//   clk, reset : clock, synchronous active-high reset
//   en         : advance the line
//   clr        : zero every stage (has priority over en)
//   din / dout : lane input / delayed lane output
// ----------------------------------------------------------------------------
module sta_skew_line #(
  parameter int DEPTH = 0,
  parameter int VEC_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  input  logic [VEC_W-1:0][7:0]  din,
  output logic [VEC_W-1:0][7:0]  dout
);

  if (DEPTH == 0) begin : g_pass
    assign dout = din;
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, en, clr};
  end else begin : g_dly
    logic [DEPTH-1:0][VEC_W-1:0][7:0] line_q, line_d;

    always_comb begin
      line_d = line_q;
      if (clr) begin
        line_d = '0;
      end else if (en) begin
        line_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          line_d[i] = line_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) line_q <= '0;
      else       line_q <= line_d;
    end

    assign dout = line_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_tensor_array_gen.sv
// ----------------------------------------------------------------------------
// systolic_tensor_array_gen
// ROWS x COLS grid of VEC_W-wide int8 dot-product PEs with int32
// accumulators. Inputs are skewed internally; a tile FSM sequences
// BIAS -> FEED -> FLUSH -> DRAIN and results leave one row per beat.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a tile (IDLE only)
//   k_steps    : number of K beats, latched on start
//   bias_in    : per-column int32 bias, latched on start
//   pe_mask    : per-PE enable, index r*COLS+c, latched on start
//   busy       : FSM not in IDLE
//   done       : one-cycle pulse after the last drain beat is accepted
//   sat_flag   : sticky clip indicator (only with STA_SAT_ACC_EN)
//   bus        : operand/result streams (systolic_tensor_array_gen_if.slave)
// Build option: define STA_SAT_ACC_EN for saturating accumulation and the
// sat_flag port; otherwise accumulation wraps modulo 2^32.
// ----------------------------------------------------------------------------
module systolic_tensor_array_gen
  import sta_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int VEC_W  = 4,
  parameter int KCNT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [KCNT_W-1:0]           k_steps,
  input  logic [COLS-1:0][ACC_W-1:0]  bias_in,
  input  logic [ROWS*COLS-1:0]        pe_mask,
  output logic                        busy,
  output logic                        done,
`ifdef STA_SAT_ACC_EN
  output logic                        sat_flag,
`endif
  systolic_tensor_array_gen_if.slave  bus
);

  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FL_W  = $clog2(ROWS + COLS);
  localparam int DOT_W = dot_w(VEC_W);

  typedef logic [VEC_W-1:0][7:0] vec_t;

  // --------------------------------------------------------------------------
  // Arithmetic helpers
  // --------------------------------------------------------------------------
  function automatic logic signed [ACC_W-1:0] dot_prod(input vec_t a, input vec_t b);
    logic signed [DOT_W-1:0] sum;
    logic signed [15:0]      p;
    int8_t                   ai, bi;
    sum = '0;
    for (int i = 0; i < VEC_W; i++) begin
      ai  = a[i];
      bi  = b[i];
      p   = 16'(ai) * 16'(bi);
      sum = sum + DOT_W'(p);
    end
    return ACC_W'(sum);
  endfunction

`ifdef STA_SAT_ACC_EN
  function automatic logic acc_clips(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] d);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {d[ACC_W-1], d};
    return s[ACC_W] != s[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] d);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {d[ACC_W-1], d};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction
`else
  function automatic logic signed [ACC_W-1:0] acc_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] d);
    return a + d;
  endfunction
`endif

  // --------------------------------------------------------------------------
  // Tile control
  // --------------------------------------------------------------------------
  sta_state_e                 state_q, state_d;
  logic [KCNT_W-1:0]          beat_q, beat_d;
  logic [KCNT_W-1:0]          kst_q, kst_d;
  logic [FL_W-1:0]            flush_q, flush_d;
  logic [RW-1:0]              row_q, row_d;
  logic [COLS-1:0][ACC_W-1:0] bias_q, bias_d;
  logic [ROWS*COLS-1:0]       mask_q, mask_d;
  logic                       done_q, done_d;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    kst_d   = kst_q;
    flush_d = flush_q;
    row_d   = row_q;
    bias_d  = bias_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          kst_d   = k_steps;
          bias_d  = bias_in;
          mask_d  = pe_mask;
          state_d = BIAS;
        end
      end
      BIAS: begin
        beat_d  = '0;
        flush_d = '0;
        row_d   = '0;
        state_d = (kst_q != '0) ? FEED : DRAIN;
      end
      FEED: begin
        if (bus.in_valid) begin
          beat_d = beat_q + KCNT_W'(1);
          if (beat_q == kst_q - KCNT_W'(1)) state_d = FLUSH;
        end
      end
      // Last beat needs ROWS+COLS-2 further cycles to reach the far corner.
      FLUSH: begin
        flush_d = flush_q + FL_W'(1);
        if (flush_q == FL_W'(ROWS + COLS - 2)) state_d = DRAIN;
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      kst_q   <= '0;
      flush_q <= '0;
      row_q   <= '0;
      bias_q  <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      kst_q   <= kst_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      bias_q  <= bias_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == FEED);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_row   = row_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

  // --------------------------------------------------------------------------
  // Stage 0: input injection and skew lines
  // --------------------------------------------------------------------------
  logic feed_beat, adv, clr;
  assign feed_beat = (state_q == FEED) && bus.in_valid;
  assign adv       = feed_beat || (state_q == FLUSH);
  assign clr       = (state_q == BIAS);

  vec_t inj_a  [ROWS];
  vec_t inj_b  [COLS];
  vec_t skew_a [ROWS];
  vec_t skew_b [COLS];

  always_comb begin
    for (int r = 0; r < ROWS; r++) inj_a[r] = feed_beat ? bus.a_in[r] : '0;
    for (int c = 0; c < COLS; c++) inj_b[c] = feed_beat ? bus.b_in[c] : '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_skew_a
    sta_skew_line #(.DEPTH(r), .VEC_W(VEC_W)) u_line (
      .clk(clk), .reset(reset), .en(adv), .clr(clr),
      .din(inj_a[r]), .dout(skew_a[r])
    );
  end

  for (genvar c = 0; c < COLS; c++) begin : g_skew_b
    sta_skew_line #(.DEPTH(c), .VEC_W(VEC_W)) u_line (
      .clk(clk), .reset(reset), .en(adv), .clr(clr),
      .din(inj_b[c]), .dout(skew_b[c])
    );
  end

  // --------------------------------------------------------------------------
  // Stage 1: PE grid (A right, B down, one register per PE)
  // --------------------------------------------------------------------------
  vec_t                    a_out    [ROWS][COLS];
  vec_t                    b_out    [ROWS][COLS];
  logic signed [ACC_W-1:0] acc_view [ROWS][COLS];
`ifdef STA_SAT_ACC_EN
  logic [ROWS*COLS-1:0]    clip;
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      vec_t                    a_pe, b_pe, a_q, a_d, b_q, b_d;
      logic signed [ACC_W-1:0] acc_q, acc_d;
      logic                    active;

      if (c == 0) begin : g_a_edge
        assign a_pe = skew_a[r];
      end else begin : g_a_chain
        assign a_pe = a_out[r][c-1];
      end
      if (r == 0) begin : g_b_edge
        assign b_pe = skew_b[c];
      end else begin : g_b_chain
        assign b_pe = b_out[r-1][c];
      end

      assign active = mask_q[r*COLS + c];

      // Masked PEs keep forwarding operands but pin their accumulator at 0.
      always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clr) begin
          a_d = '0;
          b_d = '0;
        end else if (adv) begin
          a_d = a_pe;
          b_d = b_pe;
        end
        if (!active)   acc_d = '0;
        else if (clr)  acc_d = bias_q[c];
        else if (adv)  acc_d = acc_add(acc_q, dot_prod(a_pe, b_pe));
      end

`ifdef STA_SAT_ACC_EN
      assign clip[r*COLS + c] = active && adv && !clr &&
                                acc_clips(acc_q, dot_prod(a_pe, b_pe));
`endif

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
        end
      end

      assign a_out[r][c]    = a_q;
      assign b_out[r][c]    = b_q;
      assign acc_view[r][c] = acc_q;
    end
  end

  // Operands leaving the right and bottom edges go nowhere.
  logic unused_edge;
  always_comb begin
    unused_edge = 1'b0;
    for (int r = 0; r < ROWS; r++) unused_edge = unused_edge ^ (^a_out[r][COLS-1]);
    for (int c = 0; c < COLS; c++) unused_edge = unused_edge ^ (^b_out[ROWS-1][c]);
  end

`ifdef STA_SAT_ACC_EN
  logic sat_flag_q, sat_flag_d;
  always_comb begin
    sat_flag_d = sat_flag_q | (|clip);
    if (clr) sat_flag_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) sat_flag_q <= 1'b0;
    else       sat_flag_q <= sat_flag_d;
  end
  assign sat_flag = sat_flag_q;
`endif

  // --------------------------------------------------------------------------
  // Stage 2: row drain mux (masked accumulators are already 0)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.out_data = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < COLS; c++) bus.out_data[c] = acc_view[row_q][c];
    end
  end

endmodule

// File: tb/tb_systolic_tensor_array_gen.sv
module tb_systolic_tensor_array_gen;
  import sta_pkg::*;

  localparam int R = 4;
  localparam int C = 4;
  localparam int V = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [15:0]      k_steps;
  logic [C-1:0][31:0] bias_in;
  logic [R*C-1:0]   pe_mask;
  logic             busy;
  logic             done;
`ifdef STA_SAT_ACC_EN
  logic             sat_flag;
`endif

  systolic_tensor_array_gen_if #(.ROWS(R), .COLS(C), .VEC_W(V)) bus ();

  systolic_tensor_array_gen #(.ROWS(R), .COLS(C), .VEC_W(V), .KCNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .k_steps(k_steps),
    .bias_in(bias_in), .pe_mask(pe_mask), .busy(busy), .done(done),
`ifdef STA_SAT_ACC_EN
    .sat_flag(sat_flag),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [R-1:0][V-1:0][7:0] a_beats [4];
  logic [C-1:0][V-1:0][7:0] b_beats [4];
  logic [C-1:0][31:0]       got     [R];
  logic [C-1:0][31:0]       exp_row;

  // ---------------- stimulus helpers (no comparisons inside) ----------------
  task automatic start_tile(input logic [15:0] k, input logic [C-1:0][31:0] bias,
                            input logic [R*C-1:0] mask);
    @(negedge clk);
    start = 1'b1; k_steps = k; bias_in = bias; pe_mask = mask;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap, output bit to, output bit drop);
    int g;
    to = 1'b0; drop = 1'b0;
    for (int b = 0; b < n; b++) begin
      g = 0;
      while (!bus.in_ready && g < 50) begin @(negedge clk); g++; end
      if (!bus.in_ready) begin to = 1'b1; return; end
      bus.in_valid = 1'b1; bus.a_in = a_beats[b]; bus.b_in = b_beats[b];
      @(negedge clk);
      bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0;
      if (b < n - 1) begin
        for (int i = 0; i < gap; i++) begin
          if (!bus.in_ready) drop = 1'b1;
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic drain(input int stall_row, input int stall_n, output bit to,
                       output bit seq_bad, output bit hold_bad, output int done_cnt);
    int rows_seen = 0, guard = 0, stall_left = stall_n;
    bit holding = 1'b0;
    logic [C-1:0][31:0] held = '0;
    to = 1'b0; seq_bad = 1'b0; hold_bad = 1'b0; done_cnt = 0;
    while (rows_seen < R && guard < 200) begin
      if (bus.out_valid) begin
        if (int'(bus.out_row) != rows_seen) seq_bad = 1'b1;
        if (holding && bus.out_data !== held) hold_bad = 1'b1;
        if (int'(bus.out_row) == stall_row && stall_left > 0) begin
          bus.out_ready = 1'b0;
          if (!holding) begin held = bus.out_data; holding = 1'b1; end
          stall_left--;
        end else begin
          bus.out_ready = 1'b1;
          got[rows_seen] = bus.out_data;
          rows_seen++;
          holding = 1'b0;
        end
      end
      @(negedge clk);
      guard++;
      if (done) done_cnt++;
    end
    bus.out_ready = 1'b1;
    if (rows_seen < R) to = 1'b1;
    repeat (4) begin @(negedge clk); if (done) done_cnt++; end
  endtask

  task automatic load_unit_beats();
    for (int r = 0; r < R; r++) a_beats[0][r] = {8'd0, 8'd0, 8'd0, 8'd1};
    for (int c = 0; c < C; c++) b_beats[0][c] = {8'd0, 8'd0, 8'd0, 8'(c + 1)};
  endtask

  // ------------------------------- tests ------------------------------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; k_steps = '0; bias_in = '0; pe_mask = '0;
    bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl busy=%b done=%b required 0 0", busy, done); end
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b required 0 0", bus.in_ready, bus.out_valid); end
    checks++; if (bus.out_row !== '0 || bus.out_data !== '0) begin errors++;
      $display("FAIL reset_out row=%0d data=%h required 0", bus.out_row, bus.out_data); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL idle_after_reset busy=%b required 0", busy); end
  endtask

  task automatic test_unit();
    bit to, drop, sb, hb; int dc, fl;
    load_unit_beats();
    start_tile(16'd1, '0, '1);
    feed(1, 0, to, drop);
    fl = 0;
    while (!bus.out_valid && fl < 50) begin fl++; @(negedge clk); end
    checks++; if (fl != R + C - 1) begin errors++;
      $display("FAIL unit_flush_len got %0d required %0d", fl, R + C - 1); end
    drain(-1, 0, to, sb, hb, dc);
    for (int c = 0; c < C; c++) exp_row[c] = 32'(c + 1);
    for (int r = 0; r < R; r++) begin
      checks++; if (got[r] !== exp_row) begin errors++;
        $display("FAIL unit_row%0d got %h required %h", r, got[r], exp_row); end
    end
    checks++; if (to || sb || dc != 1 || busy !== 1'b0) begin errors++;
      $display("FAIL unit_drain timeout=%b seq_bad=%b done_cnt=%0d busy=%b required 0 0 1 0", to, sb, dc, busy); end
  endtask

  task automatic test_sign_ext();
    bit to, drop, sb, hb; int dc;
    logic [C-1:0][31:0] bias;
    for (int b = 0; b < 3; b++) begin
      for (int r = 0; r < R; r++) a_beats[b][r] = {4{8'h80}};
      for (int c = 0; c < C; c++) b_beats[b][c] = {4{8'h80}};
    end
    for (int c = 0; c < C; c++) bias[c] = 32'(100 * c);
    start_tile(16'd3, bias, '1);
    feed(3, 0, to, drop);
    drain(-1, 0, to, sb, hb, dc);
    for (int c = 0; c < C; c++) exp_row[c] = 32'(196608 + 100 * c);
    for (int r = 0; r < R; r++) begin
      checks++; if (got[r] !== exp_row) begin errors++;
        $display("FAIL signext_row%0d got %h required %h", r, got[r], exp_row); end
    end
    checks++; if (to || dc != 1) begin errors++;
      $display("FAIL signext_drain timeout=%b done_cnt=%0d required 0 1", to, dc); end
  endtask

  task automatic test_stall();
    bit to, drop, sb, hb; int dc;
    for (int r = 0; r < R; r++) begin
      a_beats[0][r] = {8'd0, 8'd0, 8'd0, 8'(r + 1)};
      a_beats[1][r] = {8'd0, 8'd0, 8'd1, 8'd0};
    end
    for (int c = 0; c < C; c++) begin
      b_beats[0][c] = {8'd0, 8'd0, 8'd0, 8'(c + 1)};
      b_beats[1][c] = {8'd0, 8'd0, 8'd10, 8'd0};
    end
    for (int run = 0; run < 2; run++) begin
      start_tile(16'd2, '0, '1);
      feed(2, run * 5, to, drop);
      checks++; if (to || drop) begin errors++;
        $display("FAIL stall_feed%0d timeout=%b ready_drop=%b required 0 0", run, to, drop); end
      drain(-1, 0, to, sb, hb, dc);
      for (int r = 0; r < R; r++) begin
        for (int c = 0; c < C; c++) exp_row[c] = 32'((r + 1) * (c + 1) + 10);
        checks++; if (got[r] !== exp_row) begin errors++;
          $display("FAIL stall%0d_row%0d got %h required %h", run, r, got[r], exp_row); end
      end
    end
  endtask

  task automatic test_back_pressure();
    bit to, drop, sb, hb; int dc;
    load_unit_beats();
    start_tile(16'd1, '0, '1);
    feed(1, 0, to, drop);
    drain(1, 3, to, sb, hb, dc);
    checks++; if (to || sb || hb) begin errors++;
      $display("FAIL bp_hold timeout=%b seq_bad=%b hold_bad=%b required 0 0 0", to, sb, hb); end
    checks++; if (dc != 1) begin errors++;
      $display("FAIL bp_done got %0d pulses required 1", dc); end
    for (int c = 0; c < C; c++) exp_row[c] = 32'(c + 1);
    checks++; if (got[1] !== exp_row || got[3] !== exp_row) begin errors++;
      $display("FAIL bp_data row1=%h row3=%h required %h", got[1], got[3], exp_row); end
  endtask

  task automatic test_mask_kzero();
    bit to, sb, hb; int dc;
    start_tile(16'd0, {4{32'd7}}, 16'h8421);
    checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL kzero_bias busy=%b in_ready=%b out_valid=%b required 1 0 0", busy, bus.in_ready, bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL kzero_skip out_valid=%b in_ready=%b required 1 0", bus.out_valid, bus.in_ready); end
    drain(-1, 0, to, sb, hb, dc);
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) exp_row[c] = (c == r) ? 32'd7 : 32'd0;
      checks++; if (got[r] !== exp_row) begin errors++;
        $display("FAIL mask_row%0d got %h required %h", r, got[r], exp_row); end
    end
    checks++; if (to || dc != 1) begin errors++;
      $display("FAIL mask_drain timeout=%b done_cnt=%0d required 0 1", to, dc); end
  endtask

  task automatic test_reset_mid_flush();
    bit to, drop, sb, hb; int dc;
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < R; r++) a_beats[b][r] = {4{8'h05}};
      for (int c = 0; c < C; c++) b_beats[b][c] = {4{8'h05}};
    end
    start_tile(16'd2, {4{32'd99}}, '1);
    feed(2, 0, to, drop);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL midreset_ctrl busy=%b out_valid=%b in_ready=%b done=%b required 0", busy, bus.out_valid, bus.in_ready, done); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load_unit_beats();
    start_tile(16'd1, '0, '1);
    feed(1, 0, to, drop);
    drain(-1, 0, to, sb, hb, dc);
    for (int c = 0; c < C; c++) exp_row[c] = 32'(c + 1);
    for (int r = 0; r < R; r++) begin
      checks++; if (got[r] !== exp_row) begin errors++;
        $display("FAIL midreset_row%0d got %h required %h", r, got[r], exp_row); end
    end
    checks++; if (to || dc != 1) begin errors++;
      $display("FAIL midreset_drain timeout=%b done_cnt=%0d required 0 1", to, dc); end
  endtask

  initial begin
    test_reset();
    test_unit();
    test_sign_ext();
    test_stall();
    test_back_pressure();
    test_mask_kzero();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/systolic_tensor_array_gen.md
Name: systolic_tensor_array_gen

Overview:
- Parametrised successor of the fixed 4x4 tensor array: a ROWS x COLS grid of VEC_W-wide int8 dot-product PEs with int32 accumulators.
- Adds internal input skewing, a tile-level FSM (bias load, feed, flush, drain), valid/ready input and output handshakes, and per-row result drain.
- Sits between the tile buffers/im2col feeder and the requantise/output stage; one invocation computes one output tile.

Parameters:
- ROWS, 4, PE rows (A lanes / output rows), >=1
- COLS, 4, PE columns (B lanes / output channels), >=1
- VEC_W, 4, int8 elements per PE per step (dot-product width)
- KCNT_W, 16, width of k_steps counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a tile; sampled only in IDLE
- k_steps  in  KCNT_W  number of VEC_W-wide K beats for this tile; latched on start
- bias_in  in  COLS x 32  per-column int32 bias; latched on start, loaded into every PE of that column
- pe_mask  in  ROWS*COLS  1 = PE active; latched on start; index r*COLS+c
- in_valid  in  1  A/B beat present
- in_ready  out  1  high only in FEED
- a_in  in  ROWS x VEC_W x 8  signed A vectors, unskewed (row r beat k)
- b_in  in  COLS x VEC_W x 8  signed B vectors, unskewed (col c beat k)
- out_valid  out  1  drain beat present
- out_ready  in  1  downstream accepts drain beat
- out_row  out  $clog2(ROWS) (min 1)  row index of current drain beat
- out_data  out  COLS x 32  accumulators of row out_row; masked PEs read 0
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after the last drain beat is accepted

Behaviour:
- Reset: FSM to IDLE; all accumulators, skew registers, and pipeline registers cleared to 0. in_ready=0, out_valid=0, out_row=0, out_data=0, busy=0, done=0. Reset takes priority mid-operation and discards the tile.
- FSM:
  - IDLE: start=1 latches k_steps, bias, and mask, then goes to BIAS.
  - BIAS (1 cycle): every PE acc <= bias_in[c]; skew registers zeroed. Next is FEED if k_steps!=0, otherwise DRAIN.
  - FEED: in_ready=1. Each in_valid&&in_ready beat increments the beat counter. After beat k_steps-1 is accepted, go to FLUSH.
  - FLUSH: exactly ROWS+COLS-1 cycles, zero injected on every input lane, never stalls; then DRAIN.
  - DRAIN: out_valid=1 with out_row = 0..ROWS-1. The row advances on out_valid&&out_ready. After row ROWS-1 is accepted, done pulses for 1 cycle and the FSM returns to IDLE.
- Skew: A row r is delayed r cycles and B column c is delayed c cycles (per-lane delay lines). A moves right and B moves down through one register per PE. Beat k therefore reaches PE(r,c) at k+r+c cycles after acceptance.
- Stall: in FEED with in_valid=0, the whole datapath (skew lines, A/B registers, accumulators) holds its state. No other state stalls the datapath.
- PE: acc <= acc + sum_{i<VEC_W} sext(a[i])*sext(b[i]). Products are 16 bit, the sum is widened to 32 bit, and accumulation wraps two's-complement modulo 2^32.
- Masked PEs still clock data through to their neighbours but hold acc=0 and report 0.
- start outside IDLE is ignored. In DRAIN, out_data is held stable while out_valid&&!out_ready.
- Drain does not disturb accumulators; they are overwritten at the next BIAS.
- idle condition: busy=0. No activity scan.

Optional Feature:
- Macro STA_SAT_ACC_EN.
- When defined: accumulation saturates to [-2^31, 2^31-1], and a sticky per-tile output sat_flag (1 bit, cleared in BIAS) is set if any active PE clipped. sat_flag is valid during DRAIN.
- When undefined: wrap arithmetic applies and no sat_flag port exists.

Decomposition:
- Shared package sta_pkg: int8_t/int32_t typedefs (existing sys_types), the sta_state_e enum {IDLE,BIAS,FEED,FLUSH,DRAIN}, ACC_W=32, and the helper function for dot-product width.
- Sub-module sta_skew_line: parametrised DEPTH x VEC_W x 8 delay line with hold enable, reset to 0, DEPTH=0 passes through. Instantiated per A row and per B column.
- PE instances reuse tensor_process_elem semantics, extended with a mask input.

Test Plan:
- ROWS=COLS=VEC_W=4, k_steps=1, bias=0, all mask=1, a_in[r]={1,0,0,0}, b_in[c]={c+1,0,0,0}: each drained row reads {1,2,3,4}; done follows 4 accepted beats after FLUSH.
- k_steps=3, every element=-128, bias_in[c]=100*c: every PE = 3*4*16384 + 100c = 196608 + 100c; checks sign extension.
- k_steps=2 with in_valid=0 for 5 cycles between the beats: results equal the no-gap run, and in_ready stays 1 throughout FEED.
- out_ready held low 3 cycles on row 1: out_row and out_data hold; the sequence 0,1,2,3 is unbroken; exactly one done pulse.
- pe_mask=0x8421 (diagonal), k_steps=0, bias=7: only diagonal PEs read 7, others 0; FEED and FLUSH are skipped.
- Reset asserted mid-FLUSH, then a fresh start with k_steps=1 and unit vectors: no residue from the old tile; outputs match a clean run.
